serial_adder_ctrl: RTL and testbench

- Bit-serial add/subtract controller. It time-multiplexes one 1-bit full-adder cell over WIDTH cycles to add or subtract two WIDTH-bit operands, LSB first.
- Start/done handshake; sits beside the team's gate-level and behavioural adder blocks as the low-area sequencer for them.
- A single `fa1_cell` instance does all arithmetic. The controller owns operand shifting, carry storage, bit counting and result capture.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/fa1_cell.sv | 14 +
 rtl/serial_adder_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: sequencer state encoding and
// the ceiling-log2 helper used to size counters.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fa1_cell.sv
// Purely combinational 1-bit full adder; the only arithmetic element of the
// serial adder.
module fa1_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one fa1_cell is reused LSB-first over
// WIDTH cycles, with start/done handshake and registered results.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] msb_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             cell_s_s;
  logic             cell_co_s;
  logic             last_bit_s;

  fa1_cell u_fa1_cell (
    .a  (op_a_r[0]),
    .b  (op_b_r[0]),
    .ci (carry_r),
    .s  (cell_s_s),
    .co (cell_co_s)
  );

  assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

  // Accumulator shifts right; the new sum bit enters at the MSB.
  always_comb begin
    msb_s            = '0;
    msb_s[WIDTH-1]   = cell_s_s;
    acc_nxt_s        = (acc_r >> 1'b1) | msb_s;
  end

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_bit_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      op_a_r  <= '0;
      op_b_r  <= '0;
      acc_r   <= '0;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            op_a_r  <= a;
            op_b_r  <= sub ? ~b : b;
            carry_r <= cin ^ sub;
            cnt_r   <= '0;
            acc_r   <= '0;
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        SHIFT: begin
          op_a_r  <= op_a_r >> 1'b1;
          op_b_r  <= op_b_r >> 1'b1;
          acc_r   <= acc_nxt_s;
          carry_r <= cell_co_s;
          // Results land on the same edge that enters DONE, so they are
          // visible together with the done pulse; carry_r here is the
          // carry into the MSB.
          if (last_bit_s) begin
            sum_r  <= acc_nxt_s;
            cout_r <= cell_co_s;
            ovf_r  <= carry_r ^ cell_co_s;
          end else begin
            cnt_r  <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy = (state_r != IDLE);
  assign done = (state_r == DONE);
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: cycle model for the WIDTH=8 instance plus directed
// vectors on WIDTH=8, WIDTH=1 and WIDTH=32 instances.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  logic        start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [0:0]  a1 = 1'b0, b1 = 1'b0;
  logic        busy1, done1, cout1, ovf1;
  logic [0:0]  sum1;

  logic        start32 = 1'b0, sub32 = 1'b0, cin32 = 1'b0;
  logic [31:0] a32 = 32'd0, b32 = 32'd0;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

  serial_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32));

  int vectors = 0;
  int errors  = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: returns {ovf, cout, sum} for a w-bit operation.
  function automatic logic [33:0] calc(input int w, input logic [31:0] a, input logic [31:0] b,
                                       input logic ci, input logic sb);
    logic [63:0] mask, bb, full;
    logic [31:0] s;
    logic co, ov;
    mask = (64'd1 << w) - 64'd1;
    bb   = sb ? (~{32'd0, b}) & mask : {32'd0, b};
    full = {32'd0, a} + bb + {63'd0, ci ^ sb};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  // Cycle model of the WIDTH=8 instance: m_cnt = busy cycles remaining.
  int          m_cnt = 0;
  logic [33:0] pend = 34'd0;
  logic [7:0]  m_sum = 8'd0;
  logic        m_cout = 1'b0, m_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0; m_sum <= 8'd0; m_cout <= 1'b0; m_ovf <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start8) begin
        m_cnt <= 9;
        pend  <= calc(8, {24'd0, a8}, {24'd0, b8}, cin8, sub8);
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) begin
        m_sum <= pend[7:0]; m_cout <= pend[32]; m_ovf <= pend[33];
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_busy", {31'd0, busy8}, {31'd0, m_cnt != 0});
      chk("m_done", {31'd0, done8}, {31'd0, m_cnt == 1});
      chk("m_sum",  {24'd0, sum8},  {24'd0, m_sum});
      chk("m_cout", {31'd0, cout8}, {31'd0, m_cout});
      chk("m_ovf",  {31'd0, ovf8},  {31'd0, m_ovf});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic sb, input logic [7:0] es, input logic ec, input logic eo);
    int n;
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done8 && n < 30) begin @(negedge clk); n++; end
    chk({nm, "_lat"},  n, 32'd8);
    chk({nm, "_sum"},  {24'd0, sum8},  {24'd0, es});
    chk({nm, "_cout"}, {31'd0, cout8}, {31'd0, ec});
    chk({nm, "_ovf"},  {31'd0, ovf8},  {31'd0, eo});
    tick();
  endtask

  task automatic run_o(input string nm, input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb, input logic [31:0] es,
                       input logic ec, input logic eo);
    int n;
    logic d;
    if (w == 1) begin
      a1 = a[0:0]; b1 = b[0:0]; cin1 = ci; sub1 = sb; start1 = 1'b1;
    end else begin
      a32 = a; b32 = b; cin32 = ci; sub32 = sb; start32 = 1'b1;
    end
    tick();
    start1 = 1'b0; start32 = 1'b0;
    n = 0;
    @(negedge clk);
    d = (w == 1) ? done1 : done32;
    while (!d && n < 60) begin
      @(negedge clk); n++;
      d = (w == 1) ? done1 : done32;
    end
    chk({nm, "_lat"}, n, 32'(w));
    if (w == 1) begin
      chk({nm, "_sum"},  {31'd0, sum1},  es);
      chk({nm, "_cout"}, {31'd0, cout1}, {31'd0, ec});
      chk({nm, "_ovf"},  {31'd0, ovf1},  {31'd0, eo});
    end else begin
      chk({nm, "_sum"},  sum32,           es);
      chk({nm, "_cout"}, {31'd0, cout32}, {31'd0, ec});
      chk({nm, "_ovf"},  {31'd0, ovf32},  {31'd0, eo});
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, c1, dones;
    rst = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_sum",  {24'd0, sum8},  32'd0);
    rst = 1'b0;
    tick();

    op8("add",   8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0);
    op8("wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("sovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("subb",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("subo",  8'h80, 8'h01, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1);
    op8("addc",  8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("subz",  8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

    // start pulsed 3 cycles into an operation must be ignored
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    a8 = 8'hF0; b8 = 8'h0F; sub8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done8 && n < 30) begin @(negedge clk); n++; end
    chk("busy_done_seen", {31'd0, done8}, 32'd1);
    chk("busy_sum",  {24'd0, sum8},  32'h33);
    chk("busy_cout", {31'd0, cout8}, 32'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (done8) dones++; end
    chk("busy_no_extra", dones, 32'd0);
    tick();

    // start held high: one result every WIDTH+2 cycles
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    c0 = -1; c1 = -1;
    for (int i = 0; i < 40 && c1 < 0; i++) begin
      @(negedge clk);
      if (done8) begin
        if (c0 < 0) c0 = i; else c1 = i;
      end
    end
    start8 = 1'b0;
    chk("b2b_spacing", c1 - c0, 32'd10);
    tick();

    // reset on the 4th SHIFT cycle aborts the operation
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_busy", {31'd0, busy8}, 32'd0);
    chk("rmid_sum",  {24'd0, sum8},  32'd0);
    chk("rmid_cout", {31'd0, cout8}, 32'd0);
    chk("rmid_ovf",  {31'd0, ovf8},  32'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (done8) dones++; end
    chk("rmid_no_done", dones, 32'd0);
    tick();
    op8("fresh", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    run_o("w1_add",  1, 32'd1, 32'd1, 1'b1, 1'b0, 32'd1, 1'b1, 1'b0);
    run_o("w1_plain",1, 32'd1, 32'd0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0);
    run_o("w1_sub",  1, 32'd0, 32'd1, 1'b0, 1'b1, 32'd1, 1'b0, 1'b1);
    run_o("w32_wrap",32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_o("w32_ovf", 32, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
